// File: rtl/wb_commit_reg_if.sv
// M-to-W commit bus for wb_commit_reg: M-stage instruction inputs and W-stage write port.
// With WB_COMMIT_STATS_EN defined the bus also carries the squash statistics counter.
interface wb_commit_reg_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 4
) ();
    logic              i_valid;
    logic              i_stall;
    logic [SEL_W-1:0]  i_regdst_sel;
    logic [REG_AW-1:0] i_a3;
    logic [DATA_W-1:0] i_wdata;
    logic              i_ovf_instr;
    logic              i_ovf;
    logic              i_req;
    logic              o_valid;
    logic [REG_AW-1:0] o_a3;
    logic [DATA_W-1:0] o_wdata;
    logic              o_we;
    logic              o_draining;
`ifdef WB_COMMIT_STATS_EN
    logic [31:0]       o_squash_cnt;

    modport master (
        output i_valid, i_stall, i_regdst_sel, i_a3, i_wdata, i_ovf_instr, i_ovf, i_req,
        input  o_valid, o_a3, o_wdata, o_we, o_draining, o_squash_cnt
    );
    modport slave (
        input  i_valid, i_stall, i_regdst_sel, i_a3, i_wdata, i_ovf_instr, i_ovf, i_req,
        output o_valid, o_a3, o_wdata, o_we, o_draining, o_squash_cnt
    );
`else
    modport master (
        output i_valid, i_stall, i_regdst_sel, i_a3, i_wdata, i_ovf_instr, i_ovf, i_req,
        input  o_valid, o_a3, o_wdata, o_we, o_draining
    );
    modport slave (
        input  i_valid, i_stall, i_regdst_sel, i_a3, i_wdata, i_ovf_instr, i_ovf, i_req,
        output o_valid, o_a3, o_wdata, o_we, o_draining
    );
`endif
endinterface

// File: rtl/wb_commit_reg.sv
// W-stage commit register: gates register-file writes and suppresses them for a fixed number
// of advancing cycles after an exception request. Optional macro: WB_COMMIT_STATS_EN.
module wb_commit_reg #(
    parameter int unsigned            REG_AW       = 5,
    parameter int unsigned            DATA_W       = 32,
    parameter int unsigned            SEL_W        = 4,
    parameter logic [(2**SEL_W)-1:0]  WR_SEL_MASK  = 'h000F,
    parameter int unsigned            DRAIN_CYCLES = 3
) (
    input  logic           clk,
    input  logic           reset,
    wb_commit_reg_if.slave bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q;
    logic              we_q;
    logic [REG_AW-1:0] a3_q;
    logic [DATA_W-1:0] wdata_q;
    logic              writer;
    logic              commit;

    // A "writer" is a real instruction that would write a non-zero register.
    always_comb begin
        writer = bus.i_valid && WR_SEL_MASK[bus.i_regdst_sel] && (bus.i_a3 != '0);
        commit = writer && !(bus.i_ovf_instr && bus.i_ovf) && !bus.i_req && (state_q == StRun);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.i_stall) begin
            if (bus.i_req) begin
                state_d = StDrain;
                cnt_d   = CNT_W'(DRAIN_CYCLES);
            end else if (state_q == StDrain) begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StRun;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            a3_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!bus.i_stall) begin
                valid_q <= bus.i_valid && !bus.i_req;
                we_q    <= commit;
                a3_q    <= commit ? bus.i_a3 : '0;
                wdata_q <= bus.i_wdata;
            end
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_we       = we_q;
    assign bus.o_a3       = a3_q;
    assign bus.o_wdata    = wdata_q;
    assign bus.o_draining = (state_q == StDrain);

`ifdef WB_COMMIT_STATS_EN
    logic [31:0] squash_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            squash_q <= '0;
        end else if (!bus.i_stall && writer && !commit) begin
            squash_q <= squash_q + 32'd1;
        end
    end

    assign bus.o_squash_cnt = squash_q;
`endif

endmodule
